// File: rtl/bdi_comp_pkg.sv
// Shared widths, encoding enum, FSM states and the compressed-length table
// for the BDI compressor scheduler.
package bdi_comp_pkg;

   localparam int LINE_W = 256;
   localparam int CMP_W  = 260;
   localparam int LEN_W  = 9;

   typedef enum logic [3:0] {
      ENC_ZERO = 4'd0,
      ENC_B8D1 = 4'd1,
      ENC_B8D2 = 4'd2,
      ENC_B8D4 = 4'd3,
      ENC_B4D1 = 4'd4,
      ENC_B4D2 = 4'd5,
      ENC_B2D1 = 4'd6,
      ENC_REP  = 4'd7,
      ENC_RAW  = 4'd8
   } enc_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_OUT   = 2'd3
   } state_e;

   // Unknown encodings map to the raw length so callers never see a short mask.
   function automatic logic [LEN_W-1:0] enc_len(input logic [3:0] enc);
      case (enc)
         ENC_ZERO: enc_len = 9'd12;
         ENC_B8D1: enc_len = 9'd103;
         ENC_B8D2: enc_len = 9'd135;
         ENC_B8D4: enc_len = 9'd199;
         ENC_B4D1: enc_len = 9'd107;
         ENC_B4D2: enc_len = 9'd171;
         ENC_B2D1: enc_len = 9'd163;
         ENC_REP:  enc_len = 9'd68;
         default:  enc_len = 9'd260;
      endcase
   endfunction

endpackage

// File: rtl/bdi_comp_sched_rr_arbiter.sv
// Combinational round-robin grant: first valid requester at or above ptr,
// wrapping modulo NREQ. The pointer itself lives in the parent.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 3
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_idx
);

   int idx;

   // Walk from farthest to nearest so the nearest valid requester wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      idx     = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NREQ;
         if (req[idx]) begin
            gnt      = '0;
            gnt[idx] = 1'b1;
            gnt_idx  = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/bdi_comp_sched.sv
// Round-robin scheduler sharing one BDI compressor among NREQ line requesters.
// Optional statistics counters and readout port are enabled by BDI_SCHED_STATS_EN.
module bdi_comp_sched
   import bdi_comp_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int IDW     = 3,
   parameter int TIMEOUT = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*LINE_W-1:0] req_line,
   output logic [NREQ-1:0]        req_ready,
   output logic                   cmp_valid,
   output logic [LINE_W-1:0]      cmp_line,
   input  logic                   cmp_done,
   input  logic [CMP_W-1:0]       cmp_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [CMP_W-1:0]       out_data,
   output logic [LEN_W-1:0]       out_len,
   output logic [IDW-1:0]         out_src,
   output logic                   busy
`ifdef BDI_SCHED_STATS_EN
   ,
   input  logic [3:0]             stat_sel,
   output logic [31:0]            stat_cnt
`endif
);

   localparam int CNT_W = $clog2(TIMEOUT);

   state_e              state_q, state_d;
   logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]      src_q, src_d;
   logic [LINE_W-1:0]   cmp_line_q, cmp_line_d;
   logic                cmp_valid_q, cmp_valid_d;
   logic                out_valid_q, out_valid_d;
   logic [CMP_W-1:0]    out_data_q, out_data_d;
   logic [LEN_W-1:0]    out_len_q, out_len_d;
   logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
   logic [NREQ-1:0]     gnt;
   logic [IDW-1:0]      gnt_idx;
   logic [LINE_W-1:0]   sel_line;
   logic [LEN_W-1:0]    done_len;
   logic [CMP_W-1:0]    len_mask;
   logic                enc_legal;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req     (req_valid),
      .ptr     (rr_ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   // Gating with rst_n keeps req_ready low while reset is held.
   assign req_ready = (state_q == S_IDLE && rst_n) ? gnt : '0;
   assign cmp_valid = cmp_valid_q;
   assign cmp_line  = cmp_line_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_len   = out_len_q;
   assign out_src   = src_q;
   assign busy      = (state_q != S_IDLE);

   assign done_len  = enc_len(cmp_data[3:0]);
   assign enc_legal = (cmp_data[3:0] <= ENC_RAW);
   assign len_mask  = (CMP_W'(1) << done_len) - CMP_W'(1);

   always_comb begin
      sel_line = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) sel_line = req_line[i*LINE_W +: LINE_W];
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      src_d       = src_q;
      cmp_line_d  = cmp_line_q;
      cmp_valid_d = 1'b0;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_len_d   = out_len_q;
      wait_cnt_d  = wait_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (|req_ready) begin
               cmp_line_d  = sel_line;
               src_d       = gnt_idx;
               rr_ptr_d    = IDW'((int'(gnt_idx) + 1) % NREQ);
               cmp_valid_d = 1'b1;
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            wait_cnt_d = '0;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            if (cmp_done && enc_legal) begin
               out_data_d  = cmp_data & len_mask;
               out_len_d   = done_len;
               out_valid_d = 1'b1;
               state_d     = S_OUT;
            end else if (cmp_done || wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
               out_data_d  = {cmp_line_q, 4'd8};
               out_len_d   = LEN_W'(CMP_W);
               out_valid_d = 1'b1;
               state_d     = S_OUT;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         S_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rr_ptr_q    <= '0;
         src_q       <= '0;
         cmp_line_q  <= '0;
         cmp_valid_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_len_q   <= '0;
         wait_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         src_q       <= src_d;
         cmp_line_q  <= cmp_line_d;
         cmp_valid_q <= cmp_valid_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_len_q   <= out_len_d;
         wait_cnt_q  <= wait_cnt_d;
      end
   end

`ifdef BDI_SCHED_STATS_EN
   logic [3:0]  stat_idx_q, stat_idx_d;
   logic [31:0] stat_q [10];
   logic [31:0] stat_d [10];
   logic [31:0] stat_cnt_q, stat_cnt_d;

   assign stat_cnt = stat_cnt_q;

   // Counter 9 collects timeouts and illegal encodings.
   always_comb begin
      stat_idx_d = stat_idx_q;
      if (state_q == S_WAIT) stat_idx_d = (cmp_done && enc_legal) ? cmp_data[3:0] : 4'd9;
      for (int i = 0; i < 10; i++) stat_d[i] = stat_q[i];
      if (state_q == S_OUT && out_ready && stat_q[stat_idx_q] != 32'hFFFF_FFFF)
         stat_d[stat_idx_q] = stat_q[stat_idx_q] + 32'd1;
      stat_cnt_d = (stat_sel <= 4'd9) ? stat_q[stat_sel] : 32'd0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_idx_q <= '0;
         stat_cnt_q <= '0;
         for (int i = 0; i < 10; i++) stat_q[i] <= '0;
      end else begin
         stat_idx_q <= stat_idx_d;
         stat_cnt_q <= stat_cnt_d;
         for (int i = 0; i < 10; i++) stat_q[i] <= stat_d[i];
      end
   end
`endif

endmodule

// File: doc/bdi_comp_sched.md
Name: bdi_comp_sched

Overview:
Round-robin scheduler that shares one Base-Delta-Immediate compressor datapath among NREQ cache-line requesters. It accepts a 256-bit line from the winning requester and issues it to the compressor. It waits for the 260-bit compressed result and its 4-bit encoding, with a timeout fallback to uncompressed. It then presents the result, its bit length and the source ID on a valid/ready output port. It sits between the L2 fill/writeback queues and the compressed-cache write path.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 3, requester ID width, at least clog2(NREQ)
TIMEOUT, 64, maximum cycles to wait for cmp_done before the uncompressed fallback (at least 2)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester line valid
req_line  in  NREQ*256  per-requester line; requester i occupies bits [256*i+255:256*i]
req_ready  out  NREQ  one-hot accept; a transfer occurs on req_valid[i] & req_ready[i]
cmp_valid  out  1  one-cycle issue strobe to the compressor
cmp_line  out  256  latched line, held stable from ISSUE through WAIT
cmp_done  in  1  compressor result strobe
cmp_data  in  260  compressed payload, LSB-aligned; encoding in [3:0]
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_data  out  260  compressed line, LSB-aligned, zero-filled above out_len
out_len  out  9  compressed length in bits
out_src  out  IDW  index of the originating requester
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, OUT. Reset puts the FSM in IDLE, rr_ptr=0, and clears every output register (cmp_valid, out_valid, out_data, out_len, out_src, cmp_line all 0).
- IDLE: req_ready is combinational and one-hot. It selects the first i with req_valid[i] set, searching from rr_ptr upward and wrapping modulo NREQ; it is all-zero if no request is valid. On the transfer cycle: latch the line into cmp_line, latch i into src, set rr_ptr=(i+1) mod NREQ, go to ISSUE. req_ready is 0 in every other state.
- ISSUE: cmp_valid=1 for exactly one cycle, then go to WAIT with wait_cnt=0.
- WAIT: cmp_done is sampled here only; a cmp_done in ISSUE is ignored.
  - On cmp_done with encoding 0..8: capture cmp_data, set out_len from the length table, go to OUT.
  - On cmp_done with encoding 9..15 (illegal): treat as fallback.
  - If wait_cnt reaches TIMEOUT-1 without cmp_done: fallback.
  - wait_cnt saturates and does not wrap.
- Fallback: out_data={cmp_line,4'd8}, out_len=260.
- Length table (bits): enc0=12, 1=103, 2=135, 3=199, 4=107, 5=171, 6=163, 7=68, 8=260.
- Output masking: bits of cmp_data at index out_len and above are forced to 0 in out_data.
- OUT: out_valid=1 and out_data/out_len/out_src hold until out_valid & out_ready, then go to IDLE. A new grant can occur no earlier than the cycle after the handshake. There is no bypass, so a grant happens at most once every 4 cycles.
- Minimum latency is 3 cycles from the accept edge to out_valid, with cmp_done arriving on the first WAIT cycle.
- Reset asserted mid-operation abandons the in-flight line. No req_ready or out_valid glitch occurs on reset release.

Optional Feature:
BDI_SCHED_STATS_EN:
- Defined: adds input stat_sel[3:0] and output stat_cnt[31:0].
  - Per-encoding 32-bit saturating counters (9 of them, plus counter 9 for timeouts/illegal encodings) increment on each OUT handshake.
  - stat_cnt is a registered readout of counter stat_sel, one-cycle latency; stat_sel>9 reads 0.
  - Counters are cleared by rst_n.
- Undefined: these ports and counters do not exist.

Decomposition:
- Package bdi_comp_pkg holds:
  - the enc_e enum (ENC_ZERO=0, ENC_B8D1, ENC_B8D2, ENC_B8D4, ENC_B4D1, ENC_B4D2, ENC_B2D1, ENC_REP, ENC_RAW=8);
  - the length-table function enc_len();
  - the constants LINE_W=256, CMP_W=260, LEN_W=9.
- Sub-module rr_arbiter (NREQ-wide, combinational grant, pointer held in the parent).

Test Plan:
- Reset mid-WAIT with requester 1 pending: all outputs 0; after release, grants follow in order 0,1,… from rr_ptr=0.
- All four req_valid held high: grant order 0,1,2,3,0; out_src matches that order; each out_data equals the compressor model result.
- Stub returns cmp_data={…,4'd7} (the repeated-data encoding) with a 2-cycle delay: out_len=68, out_data[259:68]=0, out_valid rises exactly 4 cycles after accept.
- Stub never asserts cmp_done, TIMEOUT=64: after 64 WAIT cycles, out_data={line,4'h8} and out_len=260.
- Stub returns encoding 4'hC: fallback to the raw line with out_len=260; with the macro defined, stat_sel=9 reads 1.
- out_ready held low for 10 cycles: out_* stable, req_ready stays 0; then a single handshake returns the FSM to IDLE.
